cdc_value_launcher: RTL and testbench

- Source-domain stage that drives a downstream pulse-plus-value CDC transfer block in the sending clock domain.
- Accepts update requests and registers the value. The value is held stable, and one launch pulse is issued per transfer.
- A guard window blocks the next launch until the destination has had time to sample.
- Updates that arrive during the window are coalesced, and only the latest one is kept.

---
 rtl/cdc_pkg.sv | 18 +
 rtl/cdc_guard_timer.sv | 29 ++
 rtl/cdc_value_launcher.sv | 139 +++++++++++++
 tb/tb_cdc_value_launcher.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared types and constants for the CDC value launcher.
// The optional acknowledge path is enabled by defining CDC_VALUE_LAUNCHER_ACK_EN.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    GUARD  = 2'd2
  } state_t;

  localparam int COALESCE_CNT_W = 8;
  localparam logic [COALESCE_CNT_W-1:0] COALESCE_SAT = 8'hFF;

  function automatic logic [COALESCE_CNT_W-1:0] sat_inc(input logic [COALESCE_CNT_W-1:0] v);
    return (v == COALESCE_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cdc_guard_timer.sv
// Guard-window down-counter: loads GUARD_CYCLES-1 after a launch, then counts to zero.
module cdc_guard_timer #(
  parameter int GUARD_CYCLES = 8,
  parameter int CNT_W        = $clog2(GUARD_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(GUARD_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cdc_value_launcher.sv
// Source-domain launcher: registers a value, fires one pulse per transfer, and coalesces
// updates during the guard window. Define CDC_VALUE_LAUNCHER_ACK_EN for ack_in/ack_timeout.
module cdc_value_launcher
  import cdc_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int GUARD_CYCLES = 8,
  parameter int CNT_W        = $clog2(GUARD_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      upd_vld,
  input  logic [WIDTH-1:0]          upd_data,
`ifdef CDC_VALUE_LAUNCHER_ACK_EN
  input  logic                      ack_in,
  output logic                      ack_timeout,
`endif
  output logic [WIDTH-1:0]          value_out,
  output logic                      pulse_out,
  output logic                      busy,
  output logic [COALESCE_CNT_W-1:0] coalesce_cnt
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] value_nxt;
  logic             pulse_nxt;
  logic             pend_vld, pend_vld_nxt;
  logic [WIDTH-1:0] pend_data, pend_data_nxt;
  logic             coal_inc;
  logic             timer_zero;
  logic             guard_exit;
  logic             timeout_set;

  cdc_guard_timer #(
    .GUARD_CYCLES(GUARD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (state == LAUNCH),
    .dec  (state == GUARD),
    .zero (timer_zero)
  );

  // An acknowledge may end the guard window early; the counter is the fallback.
`ifdef CDC_VALUE_LAUNCHER_ACK_EN
  assign guard_exit  = (state == GUARD) && (timer_zero || ack_in);
  assign timeout_set = (state == GUARD) && timer_zero && !ack_in;
`else
  assign guard_exit  = (state == GUARD) && timer_zero;
  assign timeout_set = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    value_nxt     = value_out;
    pulse_nxt     = 1'b0;
    pend_vld_nxt  = pend_vld;
    pend_data_nxt = pend_data;
    coal_inc      = 1'b0;
    case (state)
      IDLE: begin
        if (upd_vld) begin
          value_nxt = upd_data;
          pulse_nxt = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        state_nxt = GUARD;
        if (upd_vld) begin
          pend_data_nxt = upd_data;
          pend_vld_nxt  = 1'b1;
          coal_inc      = pend_vld;
        end
      end
      GUARD: begin
        if (guard_exit) begin
          // A fresh update beats a stale pending one, which is then counted as lost.
          if (upd_vld) begin
            value_nxt    = upd_data;
            pulse_nxt    = 1'b1;
            state_nxt    = LAUNCH;
            pend_vld_nxt = 1'b0;
            coal_inc     = pend_vld;
          end else if (pend_vld) begin
            value_nxt    = pend_data;
            pulse_nxt    = 1'b1;
            state_nxt    = LAUNCH;
            pend_vld_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (upd_vld) begin
          pend_data_nxt = upd_data;
          pend_vld_nxt  = 1'b1;
          coal_inc      = pend_vld;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      value_out    <= '0;
      pulse_out    <= 1'b0;
      pend_vld     <= 1'b0;
      pend_data    <= '0;
      coalesce_cnt <= '0;
    end else begin
      state     <= state_nxt;
      value_out <= value_nxt;
      pulse_out <= pulse_nxt;
      pend_vld  <= pend_vld_nxt;
      pend_data <= pend_data_nxt;
      if (coal_inc) begin
        coalesce_cnt <= sat_inc(coalesce_cnt);
      end
    end
  end

`ifdef CDC_VALUE_LAUNCHER_ACK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_timeout <= 1'b0;
    end else if (timeout_set) begin
      ack_timeout <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = timeout_set;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_cdc_value_launcher.sv
// Directed self-checking bench for cdc_value_launcher (GUARD_CYCLES=8).
// ACK checks are included when CDC_VALUE_LAUNCHER_ACK_EN is defined.
module tb_cdc_value_launcher;

  logic       clk;
  logic       rst_n;
  logic       upd_vld;
  logic [7:0] upd_data;
  logic [7:0] value_out;
  logic       pulse_out;
  logic       busy;
  logic [7:0] coalesce_cnt;
`ifdef CDC_VALUE_LAUNCHER_ACK_EN
  logic       ack_in;
  logic       ack_timeout;
`endif

  int compared;
  int mismatched;

  cdc_value_launcher #(
    .WIDTH       (8),
    .GUARD_CYCLES(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .upd_vld     (upd_vld),
    .upd_data    (upd_data),
`ifdef CDC_VALUE_LAUNCHER_ACK_EN
    .ack_in      (ack_in),
    .ack_timeout (ack_timeout),
`endif
    .value_out   (value_out),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .coalesce_cnt(coalesce_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; the call returns one falling edge later,
  // so outputs then reflect the rising edge that sampled these inputs.
  task automatic applyStimulus(input logic vld, input logic [7:0] data);
    upd_vld  = vld;
    upd_data = data;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int last_pulse;
    int n_pulses;
    logic [7:0] last_val;
    logic [7:0] d;

    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    upd_vld    = 1'b0;
    upd_data   = 8'h00;
`ifdef CDC_VALUE_LAUNCHER_ACK_EN
    ack_in     = 1'b0;
`endif

    // Reset, then a single update
    repeat (3) @(negedge clk);
    checkOutput("rst_value", value_out, 8'h00);
    checkOutput("rst_pulse", pulse_out, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_coal", coalesce_cnt, 8'h00);
    rst_n = 1'b1;
    repeat (3) applyStimulus(1'b0, 8'h00);
    checkOutput("idle_busy", busy, 1'b0);
    applyStimulus(1'b1, 8'hA5);
    checkOutput("t1_pulse", pulse_out, 1'b1);
    checkOutput("t1_value", value_out, 8'hA5);
    checkOutput("t1_busy", busy, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 8'h00);
      checkOutput($sformatf("t1_guard_pulse_%0d", k), pulse_out, 1'b0);
      checkOutput($sformatf("t1_guard_busy_%0d", k), busy, 1'b1);
      checkOutput($sformatf("t1_guard_value_%0d", k), value_out, 8'hA5);
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("t1_idle_busy", busy, 1'b0);

    // Coalescing inside the guard window
    applyStimulus(1'b1, 8'h11);
    checkOutput("t2_pulse0", pulse_out, 1'b1);
    checkOutput("t2_value0", value_out, 8'h11);
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b1, 8'h22);
    applyStimulus(1'b1, 8'h33);
    for (int k = 3; k <= 8; k++) begin
      checkOutput($sformatf("t2_nopulse_%0d", k), pulse_out, 1'b0);
      checkOutput($sformatf("t2_hold_%0d", k), value_out, 8'h11);
      applyStimulus(1'b0, 8'h00);
    end
    checkOutput("t2_pulse1", pulse_out, 1'b1);
    checkOutput("t2_value1", value_out, 8'h33);
    checkOutput("t2_coal", coalesce_cnt, 8'h01);
    repeat (9) applyStimulus(1'b0, 8'h00);
    checkOutput("t2_idle_busy", busy, 1'b0);
    checkOutput("t2_idle_value", value_out, 8'h33);

    // Update colliding with a pending value on the counter=0 cycle
    applyStimulus(1'b1, 8'h40);
    checkOutput("t3_pulse0", pulse_out, 1'b1);
    applyStimulus(1'b1, 8'h44);
    repeat (7) applyStimulus(1'b0, 8'h00);
    checkOutput("t3_pre_pulse", pulse_out, 1'b0);
    checkOutput("t3_pre_coal", coalesce_cnt, 8'h01);
    applyStimulus(1'b1, 8'h55);
    checkOutput("t3_pulse1", pulse_out, 1'b1);
    checkOutput("t3_value1", value_out, 8'h55);
    checkOutput("t3_coal", coalesce_cnt, 8'h02);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 8'h00);
      checkOutput($sformatf("t3_drop_pulse_%0d", k), pulse_out, 1'b0);
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("t3_drop_pulse_9", pulse_out, 1'b0);
    checkOutput("t3_idle_busy", busy, 1'b0);
    checkOutput("t3_idle_value", value_out, 8'h55);

    // Back-to-back updates: saturation and exact pulse spacing
    last_pulse = -1;
    n_pulses   = 0;
    last_val   = 8'h55;
    for (int i = 0; i < 300; i++) begin
      d = 8'(i);
      applyStimulus(1'b1, d);
      if (pulse_out === 1'b1) begin
        n_pulses++;
        checkOutput($sformatf("t4_launch_val_%0d", i), value_out, d);
        if (last_pulse >= 0) begin
          checkOutput($sformatf("t4_spacing_%0d", i), i - last_pulse, 9);
        end
        last_pulse = i;
        last_val   = d;
      end else begin
        checkOutput($sformatf("t4_stable_%0d", i), value_out, last_val);
      end
    end
    checkOutput("t4_pulse_count", n_pulses, 34);
    checkOutput("t4_coal_sat", coalesce_cnt, 8'hFF);
    repeat (20) applyStimulus(1'b0, 8'h00);
    checkOutput("t4_drain_busy", busy, 1'b0);
    checkOutput("t4_drain_value", value_out, 8'h2B);
    checkOutput("t4_coal_hold", coalesce_cnt, 8'hFF);

    // Reset while a pending update is held in the guard window
    applyStimulus(1'b1, 8'h77);
    applyStimulus(1'b1, 8'h78);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t5_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00);
    checkOutput("t5_rst_value", value_out, 8'h00);
    checkOutput("t5_rst_busy", busy, 1'b0);
    checkOutput("t5_rst_pulse", pulse_out, 1'b0);
    checkOutput("t5_rst_coal", coalesce_cnt, 8'h00);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, 8'h00);
      checkOutput($sformatf("t5_quiet_pulse_%0d", k), pulse_out, 1'b0);
    end
    checkOutput("t5_quiet_busy", busy, 1'b0);
    applyStimulus(1'b1, 8'h66);
    checkOutput("t5_pulse", pulse_out, 1'b1);
    checkOutput("t5_value", value_out, 8'h66);

`ifdef CDC_VALUE_LAUNCHER_ACK_EN
    // Early acknowledge, then a timeout that stays sticky until reset
    applyStimulus(1'b0, 8'h00);
    ack_in = 1'b1;
    applyStimulus(1'b0, 8'h00);
    ack_in = 1'b0;
    checkOutput("ack_fast_busy", busy, 1'b0);
    checkOutput("ack_fast_timeout", ack_timeout, 1'b0);
    applyStimulus(1'b1, 8'h88);
    repeat (3) applyStimulus(1'b0, 8'h00);
    ack_in = 1'b1;
    applyStimulus(1'b0, 8'h00);
    ack_in = 1'b0;
    checkOutput("ack_g3_busy", busy, 1'b0);
    checkOutput("ack_g3_timeout", ack_timeout, 1'b0);
    applyStimulus(1'b1, 8'h99);
    repeat (8) applyStimulus(1'b0, 8'h00);
    checkOutput("ack_to_pre", ack_timeout, 1'b0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("ack_to_busy", busy, 1'b0);
    checkOutput("ack_to_set", ack_timeout, 1'b1);
    repeat (5) applyStimulus(1'b0, 8'h00);
    checkOutput("ack_to_sticky", ack_timeout, 1'b1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00);
    rst_n = 1'b1;
    checkOutput("ack_to_clear", ack_timeout, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
